bcd_time_counter: RTL and testbench
===================================

# bcd_time_counter

Time-of-day counter for the alarm clock. It keeps hours, minutes and seconds in packed BCD, advances once per 1 Hz enable, and accepts single-cycle hour/minute set pulses. It sits directly upstream of the seven-segment display driver: `o_BCD_Num` connects straight to that driver's 16-bit BCD input (4 digits, HH:MM). It also feeds the alarm comparator through `o_Min_Change`.

## Interface

**Parameters**
- `MODE_24H`, default 1. 1 selects 24-hour counting (00–23); 0 selects 12-hour counting (12, 01–11) with an AM/PM flag.

**Ports**
- `i_Clk`, input, 1: system clock. Single clock domain.
- `i_Reset`, input, 1: synchronous, active-low reset. Sampled on the rising edge of `i_Clk`.
- `i_Tick_1Hz`, input, 1: one-cycle enable at 1 Hz, synchronous to `i_Clk`.
- `i_Set_Hour`, input, 1: one-cycle pulse, already debounced. Adds one hour.
- `i_Set_Min`, input, 1: one-cycle pulse, already debounced. Adds one minute.
- `o_BCD_Num`, output, 16: {hour tens, hour ones, minute tens, minute ones}, one BCD nibble per digit.
- `o_Seconds`, output, 8: {seconds tens, seconds ones} in BCD.
- `o_PM`, output, 1: 12-hour mode gives the AM/PM flag. 24-hour mode gives 1 when hour ≥ 12.
- `o_Min_Change`, output, 1: one-cycle pulse in the cycle after the minute or hour value changes.

## Operation

**Counter structure**
- Six registered BCD digits: S0, S1, M0, M1, H0, H1.
- Every digit is always a legal BCD value (0–9). Tens digits are limited to S1 ≤ 5, M1 ≤ 5, H1 ≤ 2.
- Hours are kept as BCD digits, never as a binary value converted to BCD.

**Tick path**
- A tick applies only when `i_Tick_1Hz`=1 and both set inputs are 0.
- On a tick, S0 increments.
- Carries ripple within the same cycle: 59 s → 00 s with minute +1; 59 min → 00 min with hour +1.

**Hour wrap**
- 24-hour mode: 23 → 00.
- 12-hour mode: 11 → 12 toggles `o_PM`, and 12 → 01 leaves `o_PM` unchanged.
- In 12-hour mode the hour is never 00 and never greater than 12.

**Set path**
- Set pulses take priority over the tick. A tick arriving in the same cycle as any set pulse is discarded, not deferred.
- `i_Set_Min`: minute +1 with wrap 59 → 00 and no carry into hours. Seconds are cleared to 00.
- `i_Set_Hour`: hour +1 using the same wrap and AM/PM rules as the tick path. Minutes and seconds are unchanged.
- Both set pulses in the same cycle: both increments apply independently, and seconds are cleared.
- Set inputs held high for several cycles add one per cycle. Edge detection is the upstream block's job.

**o_Min_Change**
- Asserted for exactly one cycle after any cycle in which M0, M1, H0 or H1 changed, whether from a tick carry or a set pulse.

## Timing

**Reset**
- While `i_Reset`=0 at a clock edge, all other inputs are ignored.
- 24-hour mode resets to 00:00:00 with `o_PM`=0.
- 12-hour mode resets to 12:00:00 with `o_PM`=0 (midnight, AM).
- `o_Min_Change` resets to 0.
- A reset in the same cycle as a tick or set pulse: reset wins.
- Normal counting resumes on the first tick after `i_Reset` returns high.

**Latency**
- All outputs are registered. A tick or set pulse sampled at edge N is visible on the outputs after edge N.
- `o_Min_Change` is high during the cycle after edge N, for one cycle only.
- The full 23:59:59 → 00:00:00 carry chain resolves in a single cycle.

**Other**
- No handshake and no backpressure.
- An input pulse is consumed in the cycle it is sampled.

## Test plan

- **Reset and first tick:** hold `i_Reset`=0 for 3 cycles, release, apply 1 tick → `o_BCD_Num`=16'h0000, `o_Seconds`=8'h01, `o_Min_Change`=0.
- **24-hour midnight rollover:** set the time to 23:59:58, apply 2 ticks → after the first, `o_Seconds`=8'h59; after the second, `o_BCD_Num`=16'h0000, `o_Seconds`=8'h00, `o_PM`=0, `o_Min_Change` pulses for one cycle.
- **12-hour boundaries (`MODE_24H`=0):** after reset the display is 16'h1200 AM. Drive to 11:59:59 AM, tick → 16'h1200, `o_PM`=1. Drive to 12:59:59 PM, tick → 16'h0100, `o_PM`=1.
- **Set without carry:** at 10:59:37, pulse `i_Set_Min` → 16'h1000, seconds 8'h00. Then pulse `i_Set_Hour` 14 times from 10 → 16'h0000 (24-hour mode).
- **Simultaneous events:** at 05:30:59, assert tick, `i_Set_Min` and `i_Set_Hour` in the same cycle → 16'h0631, seconds 8'h00, and the tick is lost (seconds stay 00 on the next cycle).
- **Reset mid-operation:** at 17:45:12, assert `i_Reset`=0 in the same cycle as a tick → next cycle reads 16'h0000, seconds 00. Ticks during reset produce no count.

Source files
------------

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - packed-BCD hh:mm:ss time-of-day counter with set pulses
module bcd_time_counter #(
    parameter int MODE_24H = 1
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Tick_1Hz,
    input  logic        i_Set_Hour,
    input  logic        i_Set_Min,
    output logic [15:0] o_BCD_Num,
    output logic [7:0]  o_Seconds,
    output logic        o_PM,
    output logic        o_Min_Change
);

    logic [3:0] s0_q, s0_d, s1_q, s1_d;
    logic [3:0] m0_q, m0_d, m1_q, m1_d;
    logic [3:0] h0_q, h0_d, h1_q, h1_d;
    logic       pm_q, pm_d;
    logic       min_chg_q, min_chg_d;

    logic tick, sec_wrap, min_wrap, inc_min, inc_hour;

    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        m0_d = m0_q;
        m1_d = m1_q;
        h0_d = h0_q;
        h1_d = h1_q;
        pm_d = pm_q;

        // Any set pulse swallows a coincident tick.
        tick     = i_Tick_1Hz && !i_Set_Hour && !i_Set_Min;
        sec_wrap = (s1_q == 4'd5) && (s0_q == 4'd9);
        min_wrap = (m1_q == 4'd5) && (m0_q == 4'd9);
        inc_min  = (tick && sec_wrap) || i_Set_Min;
        inc_hour = (tick && sec_wrap && min_wrap) || i_Set_Hour;

        if (tick) begin
            if (s0_q == 4'd9) begin
                s0_d = 4'd0;
                s1_d = (s1_q == 4'd5) ? 4'd0 : s1_q + 4'd1;
            end else begin
                s0_d = s0_q + 4'd1;
            end
        end

        if (i_Set_Min) begin
            s0_d = 4'd0;
            s1_d = 4'd0;
        end

        if (inc_min) begin
            if (m0_q == 4'd9) begin
                m0_d = 4'd0;
                m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
            end else begin
                m0_d = m0_q + 4'd1;
            end
        end

        if (inc_hour) begin
            if (MODE_24H != 0) begin
                if (h1_q == 4'd2 && h0_q == 4'd3) begin
                    h1_d = 4'd0;
                    h0_d = 4'd0;
                end else if (h0_q == 4'd9) begin
                    h0_d = 4'd0;
                    h1_d = h1_q + 4'd1;
                end else begin
                    h0_d = h0_q + 4'd1;
                end
            end else begin
                // 12-hour sequence 12,01..11; AM/PM flips entering 12.
                if (h1_q == 4'd1 && h0_q == 4'd2) begin
                    h1_d = 4'd0;
                    h0_d = 4'd1;
                end else if (h1_q == 4'd1 && h0_q == 4'd1) begin
                    h0_d = 4'd2;
                    pm_d = !pm_q;
                end else if (h0_q == 4'd9) begin
                    h0_d = 4'd0;
                    h1_d = 4'd1;
                end else begin
                    h0_d = h0_q + 4'd1;
                end
            end
        end

        if (MODE_24H != 0) begin
            pm_d = (h1_d == 4'd2) || (h1_d == 4'd1 && h0_d >= 4'd2);
        end

        min_chg_d = ({h1_d, h0_d, m1_d, m0_d} != {h1_q, h0_q, m1_q, m0_q});
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            s0_q      <= 4'd0;
            s1_q      <= 4'd0;
            m0_q      <= 4'd0;
            m1_q      <= 4'd0;
            h0_q      <= (MODE_24H != 0) ? 4'd0 : 4'd2;
            h1_q      <= (MODE_24H != 0) ? 4'd0 : 4'd1;
            pm_q      <= 1'b0;
            min_chg_q <= 1'b0;
        end else begin
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            m0_q      <= m0_d;
            m1_q      <= m1_d;
            h0_q      <= h0_d;
            h1_q      <= h1_d;
            pm_q      <= pm_d;
            min_chg_q <= min_chg_d;
        end
    end

    assign o_BCD_Num    = {h1_q, h0_q, m1_q, m0_q};
    assign o_Seconds    = {s1_q, s0_q};
    assign o_PM         = pm_q;
    assign o_Min_Change = min_chg_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - self-checking bench for both 24h and 12h counter variants
module tb_bcd_time_counter;

    logic        clk;
    logic        rst_n, tick, set_h, set_m;
    logic [15:0] bcd24, bcd12;
    logic [7:0]  sec24, sec12;
    logic        pm24, pm12, mc24, mc12;

    int checks = 0;
    int errors = 0;

    // Reference: time of day as seconds since midnight.
    int t_m;
    bit mc_m;

    bcd_time_counter #(.MODE_24H(1)) dut24 (
        .i_Clk(clk), .i_Reset(rst_n), .i_Tick_1Hz(tick),
        .i_Set_Hour(set_h), .i_Set_Min(set_m),
        .o_BCD_Num(bcd24), .o_Seconds(sec24), .o_PM(pm24), .o_Min_Change(mc24)
    );

    bcd_time_counter #(.MODE_24H(0)) dut12 (
        .i_Clk(clk), .i_Reset(rst_n), .i_Tick_1Hz(tick),
        .i_Set_Hour(set_h), .i_Set_Min(set_m),
        .o_BCD_Num(bcd12), .o_Seconds(sec12), .o_PM(pm12), .o_Min_Change(mc12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          h, m, s;
        bit          tk, sh, sm;
        logic [15:0] e_bcd;
        logic [7:0]  e_sec;
        bit          e_pm;
        bit          e_mc;
        logic [15:0] e_bcd12;
        bit          e_pm12;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [7:0] bcd2(int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [15:0] exp_bcd24();
        return {bcd2(t_m / 3600), bcd2((t_m / 60) % 60)};
    endfunction

    function automatic logic [15:0] exp_bcd12();
        int h;
        h = (t_m / 3600) % 12;
        if (h == 0) h = 12;
        return {bcd2(h), bcd2((t_m / 60) % 60)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(bit r, bit tk, bit sh, bit sm);
        int old_hm, h, m, s;
        rst_n = r;
        tick  = tk;
        set_h = sh;
        set_m = sm;
        old_hm = t_m / 60;
        if (!r) begin
            t_m  = 0;
            mc_m = 0;
        end else begin
            if (sh || sm) begin
                h = t_m / 3600;
                m = (t_m / 60) % 60;
                s = t_m % 60;
                if (sh) h = (h + 1) % 24;
                if (sm) begin
                    m = (m + 1) % 60;
                    s = 0;
                end
                t_m = h * 3600 + m * 60 + s;
            end else if (tk) begin
                t_m = (t_m + 1) % 86400;
            end
            mc_m = (t_m / 60) != old_hm;
        end
        @(negedge clk);
    endtask

    task automatic check_model(string tag);
        chk({tag, "_bcd24"}, 32'(bcd24), 32'(exp_bcd24()));
        chk({tag, "_sec24"}, 32'(sec24), 32'(bcd2(t_m % 60)));
        chk({tag, "_pm24"},  32'(pm24),  32'(t_m >= 12 * 3600));
        chk({tag, "_mc24"},  32'(mc24),  32'(mc_m));
        chk({tag, "_bcd12"}, 32'(bcd12), 32'(exp_bcd12()));
        chk({tag, "_sec12"}, 32'(sec12), 32'(bcd2(t_m % 60)));
        chk({tag, "_pm12"},  32'(pm12),  32'(t_m >= 12 * 3600));
        chk({tag, "_mc12"},  32'(mc12),  32'(mc_m));
    endtask

    task automatic go_to(int h, int m, int s);
        repeat (3) step(0, 0, 0, 0);
        repeat (h) step(1, 0, 1, 0);
        repeat (m) step(1, 0, 0, 1);
        repeat (s) step(1, 1, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        tick  = 1'b0;
        set_h = 1'b0;
        set_m = 1'b0;
        t_m   = 0;
        mc_m  = 0;

        vecs[0] = '{23, 59, 58, 1, 0, 0, 16'h2359, 8'h59, 1, 0, 16'h1159, 1};
        vecs[1] = '{23, 59, 59, 1, 0, 0, 16'h0000, 8'h00, 0, 1, 16'h1200, 0};
        vecs[2] = '{11, 59, 59, 1, 0, 0, 16'h1200, 8'h00, 1, 1, 16'h1200, 1};
        vecs[3] = '{12, 59, 59, 1, 0, 0, 16'h1300, 8'h00, 1, 1, 16'h0100, 1};
        vecs[4] = '{10, 59, 37, 0, 0, 1, 16'h1000, 8'h00, 0, 1, 16'h1000, 0};
        vecs[5] = '{ 5, 30, 59, 1, 1, 1, 16'h0631, 8'h00, 0, 1, 16'h0631, 0};
        vecs[6] = '{ 9, 59, 59, 1, 0, 0, 16'h1000, 8'h00, 0, 1, 16'h1000, 0};
        vecs[7] = '{ 0,  0,  0, 1, 0, 0, 16'h0000, 8'h01, 0, 0, 16'h1200, 0};
        vecs[8] = '{23, 15, 20, 0, 1, 0, 16'h0015, 8'h20, 0, 1, 16'h1215, 0};
        vecs[9] = '{19, 42,  7, 0, 0, 0, 16'h1942, 8'h07, 1, 0, 16'h0742, 1};

        @(negedge clk);

        // Reset state, then first tick
        repeat (3) step(0, 1, 1, 1);
        chk("rst_bcd24", 32'(bcd24), 32'h0000);
        chk("rst_sec24", 32'(sec24), 32'h00);
        chk("rst_pm24",  32'(pm24),  32'h0);
        chk("rst_mc24",  32'(mc24),  32'h0);
        chk("rst_bcd12", 32'(bcd12), 32'h1200);
        chk("rst_pm12",  32'(pm12),  32'h0);
        step(1, 1, 0, 0);
        chk("tick1_bcd", 32'(bcd24), 32'h0000);
        chk("tick1_sec", 32'(sec24), 32'h01);
        chk("tick1_mc",  32'(mc24),  32'h0);

        // Table-driven boundary vectors
        for (int i = 0; i < 10; i++) begin
            go_to(vecs[i].h, vecs[i].m, vecs[i].s);
            step(1, vecs[i].tk, vecs[i].sh, vecs[i].sm);
            chk($sformatf("v%0d_bcd24", i), 32'(bcd24), 32'(vecs[i].e_bcd));
            chk($sformatf("v%0d_sec24", i), 32'(sec24), 32'(vecs[i].e_sec));
            chk($sformatf("v%0d_pm24", i),  32'(pm24),  32'(vecs[i].e_pm));
            chk($sformatf("v%0d_mc24", i),  32'(mc24),  32'(vecs[i].e_mc));
            chk($sformatf("v%0d_bcd12", i), 32'(bcd12), 32'(vecs[i].e_bcd12));
            chk($sformatf("v%0d_sec12", i), 32'(sec12), 32'(vecs[i].e_sec));
            chk($sformatf("v%0d_pm12", i),  32'(pm12),  32'(vecs[i].e_pm12));
            chk($sformatf("v%0d_mc12", i),  32'(mc12),  32'(vecs[i].e_mc));
            step(1, 0, 0, 0);
            chk($sformatf("v%0d_hold_sec", i), 32'(sec24), 32'(vecs[i].e_sec));
            chk($sformatf("v%0d_mc_off24", i), 32'(mc24), 32'h0);
            chk($sformatf("v%0d_mc_off12", i), 32'(mc12), 32'h0);
        end

        // Minute set without carry, then hour set through the 23->00 wrap
        go_to(10, 59, 37);
        step(1, 0, 0, 1);
        chk("setmin_bcd", 32'(bcd24), 32'h1000);
        chk("setmin_sec", 32'(sec24), 32'h00);
        repeat (14) step(1, 0, 1, 0);
        chk("sethr14_bcd24", 32'(bcd24), 32'h0000);
        chk("sethr14_bcd12", 32'(bcd12), 32'h1200);
        chk("sethr14_pm12",  32'(pm12),  32'h0);
        chk("sethr14_pm24",  32'(pm24),  32'h0);

        // Reset mid-operation beats a coincident tick
        go_to(17, 45, 12);
        chk("pre_rst_bcd", 32'(bcd24), 32'h1745);
        chk("pre_rst_sec", 32'(sec24), 32'h12);
        step(0, 1, 0, 0);
        chk("midrst_bcd24", 32'(bcd24), 32'h0000);
        chk("midrst_sec",   32'(sec24), 32'h00);
        chk("midrst_bcd12", 32'(bcd12), 32'h1200);
        chk("midrst_pm24",  32'(pm24),  32'h0);
        step(0, 1, 0, 0);
        chk("rsttick_sec", 32'(sec24), 32'h00);
        step(1, 0, 0, 0);
        chk("release_sec", 32'(sec24), 32'h00);
        step(1, 1, 0, 0);
        chk("resume_sec", 32'(sec24), 32'h01);

        // Random: set-heavy phase, then tick-heavy phase
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
            check_model("rnd_a");
        end
        for (int n = 0; n < 2500; n++) begin
            step($urandom_range(0, 999) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 99) == 0);
            check_model("rnd_b");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
